// File: rtl/ctrl_decode_pipe_pkg.sv
// ctrl_decode_pipe_pkg: opcodes, ALU/writeback codes, FSM states and the instruction decoder
package ctrl_decode_pipe_pkg;
  localparam logic [3:0] OP_R = 4'h0, OP_ADDI = 4'h1, OP_SLTI = 4'h3, OP_LW = 4'h4;
  localparam logic [3:0] OP_SW = 4'h5, OP_BEQ = 4'h6, OP_J = 4'h7, OP_JAL = 4'h8;
  localparam logic [2:0] FC_SLL = 3'd2, FC_SRL = 3'd4, FC_JR = 3'd7;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SLT = 3'd3, ALU_EQ = 3'd7;
  localparam logic [1:0] WB_ALU = 2'd0, WB_RAM = 2'd1, WB_PC1 = 2'd2;
  typedef enum logic [1:0] {S_RUN, S_STALL, S_RESOLVE, S_FLUSH} state_t;
  typedef enum logic [1:0] {WA_RD, WA_HI, WA_RT, WA_RA} wa_t;
  typedef struct packed {
    logic       valid;
    logic [2:0] alu_cmd;
    logic       op2_imm;
    logic       shamt_sel;
    logic       ram_rd;
    logic       ram_wr;
    logic       wb_wr;
    logic [1:0] wb_src;
    logic       branch;
    logic       jump;
  } ctrl_t;
  typedef struct packed {
    ctrl_t c;
    wa_t   wa;
    logic  rs_lo;
    logic  use_rs;
    logic  use_rt;
    logic  illegal;
  } dec_t;
  // R-type fc 111 is jr; the remaining fc codes map straight onto ALU commands
  function automatic dec_t decode(input logic [15:0] ins);
    dec_t d;
    d = '0;
    d.c.valid = 1'b1;
    case (ins[15:12])
      OP_R:
        if (ins[2:0] == FC_JR) begin
          d.c.jump = 1'b1;
          d.use_rs = 1'b1;
        end else begin
          d.c.alu_cmd = ins[2:0];
          d.c.wb_wr = 1'b1;
          d.use_rs = 1'b1;
          d.rs_lo = ins[2:0] == FC_SLL || ins[2:0] == FC_SRL;
          d.c.op2_imm = d.rs_lo;
          d.c.shamt_sel = d.rs_lo;
          d.use_rt = !d.rs_lo;
          if (d.rs_lo) d.wa = WA_HI;
        end
      OP_ADDI, OP_SLTI: begin
        d.c.alu_cmd = ins[15:12] == OP_SLTI ? ALU_SLT : ALU_ADD;
        d.c.op2_imm = 1'b1;
        d.c.wb_wr = 1'b1;
        d.use_rs = 1'b1;
        d.wa = WA_RT;
      end
      OP_LW: begin
        d.c.op2_imm = 1'b1;
        d.c.ram_rd = 1'b1;
        d.c.wb_wr = 1'b1;
        d.c.wb_src = WB_RAM;
        d.use_rs = 1'b1;
        d.wa = WA_RT;
      end
      OP_SW: begin
        d.c.op2_imm = 1'b1;
        d.c.ram_wr = 1'b1;
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
      end
      OP_BEQ: begin
        d.c.alu_cmd = ALU_EQ;
        d.c.branch = 1'b1;
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
      end
      OP_J: d.c.jump = 1'b1;
      OP_JAL: begin
        d.c.jump = 1'b1;
        d.c.wb_wr = 1'b1;
        d.c.wb_src = WB_PC1;
        d.wa = WA_RA;
      end
      default: begin
        d.c.valid = 1'b0;
        d.illegal = 1'b1;
      end
    endcase
    if (ins == 16'h0000) d.c.valid = 1'b0;
    return d;
  endfunction
endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// ctrl_decode_pipe_if: fetch/EX-side bus of the decode unit; slave is the decoder's view
interface ctrl_decode_pipe_if #(parameter int REG_AW = 4);
  logic [15:0]       instr_i;
  logic              instr_valid_i, branch_resolved_i, branch_taken_i;
  logic              fetch_stall_o, flush_o;
  logic [REG_AW-1:0] addr_rs_o, addr_rt_o, ex_wb_addr_o;
  logic              ex_valid_o, ex_op2_imm_o, ex_shamt_sel_o, ex_ram_rd_o, ex_ram_wr_o, ex_wb_wr_o;
  logic [2:0]        ex_alu_cmd_o, ex_shamt_o;
  logic [1:0]        ex_wb_src_o;
  logic              ex_branch_o, ex_jump_o, illegal_o;
  logic [5:0]        ex_imm_o;
  logic [11:0]       ex_jimm_o;
  modport master (
    output instr_i, instr_valid_i, branch_resolved_i, branch_taken_i,
    input  fetch_stall_o, flush_o, addr_rs_o, addr_rt_o, ex_valid_o, ex_alu_cmd_o, ex_op2_imm_o,
           ex_shamt_sel_o, ex_ram_rd_o, ex_ram_wr_o, ex_wb_wr_o, ex_wb_addr_o, ex_wb_src_o,
           ex_branch_o, ex_jump_o, ex_imm_o, ex_shamt_o, ex_jimm_o, illegal_o
  );
  modport slave (
    input  instr_i, instr_valid_i, branch_resolved_i, branch_taken_i,
    output fetch_stall_o, flush_o, addr_rs_o, addr_rt_o, ex_valid_o, ex_alu_cmd_o, ex_op2_imm_o,
           ex_shamt_sel_o, ex_ram_rd_o, ex_ram_wr_o, ex_wb_wr_o, ex_wb_addr_o, ex_wb_src_o,
           ex_branch_o, ex_jump_o, ex_imm_o, ex_shamt_o, ex_jimm_o, illegal_o
  );
endinterface

// File: rtl/ctrl_decode_pipe_hazard.sv
// hazard_detect: load-use compare of the load sitting in EX against the decoding word's sources
module hazard_detect #(parameter int REG_AW = 4) (
  input  logic              ex_valid,
  input  logic              ex_ram_rd,
  input  logic [REG_AW-1:0] ex_wb_addr,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              hazard
);
  assign hazard = ex_valid & ex_ram_rd & ((use_rs & (ex_wb_addr == rs)) | (use_rt & (ex_wb_addr == rt)));
endmodule

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: decode into the ID/EX bundle plus stall/resolve/flush hazard control
module ctrl_decode_pipe import ctrl_decode_pipe_pkg::*; #(
  parameter int REG_AW       = 4,
  parameter int FLUSH_CYCLES = 3,
  parameter int RA_ADDR      = 2**REG_AW-1
) (
  input logic clk,
  input logic rst,
  ctrl_decode_pipe_if.slave bus
);
  localparam int CW = FLUSH_CYCLES > 0 ? $clog2(FLUSH_CYCLES+1) : 1;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d, wb_sel, addr_rs, addr_rt;
  logic [5:0]        imm_q, imm_d;
  logic [2:0]        shamt_q, shamt_d;
  logic [11:0]       jimm_q, jimm_d;
  logic              illegal_q, illegal_d;
  logic              hazard, run, hz, accept, issue, xfer;
  dec_t              dec;
  assign dec = decode(bus.instr_i);
  assign addr_rs = REG_AW'(dec.rs_lo ? bus.instr_i[8:6] : bus.instr_i[11:9]);
  assign addr_rt = REG_AW'(bus.instr_i[8:6]);
  assign wb_sel = dec.wa == WA_RA ? REG_AW'(RA_ADDR) :
                  dec.wa == WA_HI ? REG_AW'(bus.instr_i[11:9]) :
                  dec.wa == WA_RT ? REG_AW'(bus.instr_i[8:6]) : REG_AW'(bus.instr_i[5:3]);
  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid(ctrl_q.valid), .ex_ram_rd(ctrl_q.ram_rd), .ex_wb_addr(wb_addr_q),
    .use_rs(dec.use_rs), .use_rt(dec.use_rt), .rs(addr_rs), .rt(addr_rt), .hazard(hazard)
  );
  // STALL re-decodes the held word, so it accepts exactly like RUN
  assign run    = state_q == S_RUN || state_q == S_STALL;
  assign hz     = hazard & bus.instr_valid_i & run;
  assign accept = bus.instr_valid_i & run & !hz;
  assign issue  = accept & dec.c.valid;
  assign xfer   = issue & (dec.c.branch | dec.c.jump);
  always_comb begin
    ctrl_d    = issue ? dec.c : '0;
    wb_addr_d = issue && dec.c.wb_wr ? wb_sel : '0;
    imm_d     = issue ? bus.instr_i[5:0] : '0;
    shamt_d   = issue ? bus.instr_i[5:3] : '0;
    jimm_d    = issue ? bus.instr_i[11:0] : '0;
    illegal_d = accept & dec.illegal;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = state_q == S_FLUSH && cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
    case (state_q)
      S_RUN, S_STALL: state_d = xfer ? S_RESOLVE : hz ? S_STALL : S_RUN;
      S_RESOLVE:
        if (bus.branch_resolved_i) begin
          state_d = bus.branch_taken_i && FLUSH_CYCLES != 0 ? S_FLUSH : S_RUN;
          cnt_d   = bus.branch_taken_i ? CW'(FLUSH_CYCLES) : '0;
        end
      S_FLUSH: state_d = cnt_q <= CW'(1) ? S_RUN : S_FLUSH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_RUN;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      wb_addr_q <= '0;
      imm_q     <= '0;
      shamt_q   <= '0;
      jimm_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      wb_addr_q <= wb_addr_d;
      imm_q     <= imm_d;
      shamt_q   <= shamt_d;
      jimm_q    <= jimm_d;
      illegal_q <= illegal_d;
    end
  end
  assign bus.fetch_stall_o  = hz | (state_q == S_RESOLVE);
  assign bus.flush_o        = state_q == S_FLUSH;
  assign bus.addr_rs_o      = addr_rs;
  assign bus.addr_rt_o      = addr_rt;
  assign bus.ex_valid_o     = ctrl_q.valid;
  assign bus.ex_alu_cmd_o   = ctrl_q.alu_cmd;
  assign bus.ex_op2_imm_o   = ctrl_q.op2_imm;
  assign bus.ex_shamt_sel_o = ctrl_q.shamt_sel;
  assign bus.ex_ram_rd_o    = ctrl_q.ram_rd;
  assign bus.ex_ram_wr_o    = ctrl_q.ram_wr;
  assign bus.ex_wb_wr_o     = ctrl_q.wb_wr;
  assign bus.ex_wb_addr_o   = wb_addr_q;
  assign bus.ex_wb_src_o    = ctrl_q.wb_src;
  assign bus.ex_branch_o    = ctrl_q.branch;
  assign bus.ex_jump_o      = ctrl_q.jump;
  assign bus.ex_imm_o       = imm_q;
  assign bus.ex_shamt_o     = shamt_q;
  assign bus.ex_jimm_o      = jimm_q;
  assign bus.illegal_o      = illegal_q;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: directed decode, load-use stall, branch flush, jal, illegal and reset checks
module tb_ctrl_decode_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_asrt = 0;
  int   n_fail = 0;
  ctrl_decode_pipe_if #(.REG_AW(4)) bus ();
  ctrl_decode_pipe #(.REG_AW(4), .FLUSH_CYCLES(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0;
    bus.instr_i = 16'h0298;
    bus.instr_valid_i = 1'b1;
    bus.branch_resolved_i = 1'b0;
    bus.branch_taken_i = 1'b0;
    tick();
    tick();
    chk("rst_ex_valid", bus.ex_valid_o, 0);
    chk("rst_wb_wr", bus.ex_wb_wr_o, 0);
    chk("rst_wb_addr", bus.ex_wb_addr_o, 0);
    chk("rst_illegal", bus.illegal_o, 0);
    chk("rst_flush", bus.flush_o, 0);
    chk("rst_addr_rs", bus.addr_rs_o, 1);
    chk("rst_addr_rt", bus.addr_rt_o, 2);
    rst = 1'b1;
    tick();
    chk("add_valid", bus.ex_valid_o, 1);
    chk("add_alu", bus.ex_alu_cmd_o, 0);
    chk("add_wb_wr", bus.ex_wb_wr_o, 1);
    chk("add_wb_addr", bus.ex_wb_addr_o, 3);
    chk("add_wb_src", bus.ex_wb_src_o, 0);
    chk("add_op2_imm", bus.ex_op2_imm_o, 0);
    bus.instr_i = 16'h4284;
    tick();
    chk("lw_ram_rd", bus.ex_ram_rd_o, 1);
    chk("lw_wb_addr", bus.ex_wb_addr_o, 2);
    chk("lw_wb_src", bus.ex_wb_src_o, 1);
    chk("lw_imm", bus.ex_imm_o, 4);
    chk("lw_op2_imm", bus.ex_op2_imm_o, 1);
    bus.instr_i = 16'h0498;
    #1;
    chk("hz_stall", bus.fetch_stall_o, 1);
    tick();
    chk("hz_bubble", bus.ex_valid_o, 0);
    chk("hz_stall_once", bus.fetch_stall_o, 0);
    tick();
    chk("hz_add_valid", bus.ex_valid_o, 1);
    chk("hz_add_wb_addr", bus.ex_wb_addr_o, 3);
    chk("hz_add_ram_rd", bus.ex_ram_rd_o, 0);
    bus.instr_i = 16'h6283;
    tick();
    chk("beq_valid", bus.ex_valid_o, 1);
    chk("beq_branch", bus.ex_branch_o, 1);
    chk("beq_alu", bus.ex_alu_cmd_o, 7);
    chk("beq_wb_wr", bus.ex_wb_wr_o, 0);
    bus.instr_i = 16'h0298;
    #1;
    chk("resolve_stall", bus.fetch_stall_o, 1);
    tick();
    chk("resolve_bubble", bus.ex_valid_o, 0);
    chk("resolve_stall2", bus.fetch_stall_o, 1);
    bus.branch_resolved_i = 1'b1;
    bus.branch_taken_i = 1'b1;
    tick();
    bus.branch_resolved_i = 1'b0;
    bus.branch_taken_i = 1'b0;
    chk("flush_1", bus.flush_o, 1);
    chk("flush_1_valid", bus.ex_valid_o, 0);
    chk("flush_1_stall", bus.fetch_stall_o, 0);
    tick();
    chk("flush_2", bus.flush_o, 1);
    chk("flush_2_valid", bus.ex_valid_o, 0);
    tick();
    chk("flush_3", bus.flush_o, 1);
    chk("flush_3_valid", bus.ex_valid_o, 0);
    tick();
    chk("flush_end", bus.flush_o, 0);
    chk("flush_end_valid", bus.ex_valid_o, 0);
    tick();
    chk("post_flush_valid", bus.ex_valid_o, 1);
    chk("post_flush_wb_addr", bus.ex_wb_addr_o, 3);
    bus.instr_i = 16'h6283;
    tick();
    chk("beq2_branch", bus.ex_branch_o, 1);
    bus.instr_i = 16'h0298;
    tick();
    bus.branch_resolved_i = 1'b1;
    tick();
    bus.branch_resolved_i = 1'b0;
    chk("nt_no_flush", bus.flush_o, 0);
    chk("nt_no_stall", bus.fetch_stall_o, 0);
    chk("nt_bubble", bus.ex_valid_o, 0);
    tick();
    chk("nt_add_valid", bus.ex_valid_o, 1);
    chk("nt_flush_after", bus.flush_o, 0);
    bus.instr_i = 16'h8012;
    tick();
    chk("jal_valid", bus.ex_valid_o, 1);
    chk("jal_jump", bus.ex_jump_o, 1);
    chk("jal_wb_wr", bus.ex_wb_wr_o, 1);
    chk("jal_wb_addr", bus.ex_wb_addr_o, 4'hF);
    chk("jal_wb_src", bus.ex_wb_src_o, 2);
    chk("jal_jimm", bus.ex_jimm_o, 12'h012);
    bus.instr_valid_i = 1'b0;
    bus.branch_resolved_i = 1'b1;
    tick();
    bus.branch_resolved_i = 1'b0;
    chk("jal_resolved_run", bus.fetch_stall_o, 0);
    bus.instr_i = 16'hA000;
    bus.instr_valid_i = 1'b1;
    tick();
    chk("ill_pulse", bus.illegal_o, 1);
    chk("ill_bubble", bus.ex_valid_o, 0);
    bus.instr_i = 16'h0AD2;
    #1;
    chk("sll_addr_rs", bus.addr_rs_o, 3);
    tick();
    chk("ill_pulse_end", bus.illegal_o, 0);
    chk("sll_alu", bus.ex_alu_cmd_o, 2);
    chk("sll_wb_addr", bus.ex_wb_addr_o, 5);
    chk("sll_shamt", bus.ex_shamt_o, 2);
    chk("sll_shamt_sel", bus.ex_shamt_sel_o, 1);
    bus.instr_i = 16'h0000;
    tick();
    chk("nop_bubble", bus.ex_valid_o, 0);
    chk("nop_no_illegal", bus.illegal_o, 0);
    bus.instr_i = 16'h6283;
    tick();
    bus.instr_valid_i = 1'b0;
    tick();
    bus.branch_resolved_i = 1'b1;
    bus.branch_taken_i = 1'b1;
    tick();
    bus.branch_resolved_i = 1'b0;
    bus.branch_taken_i = 1'b0;
    chk("rf_flush_on", bus.flush_o, 1);
    rst = 1'b0;
    tick();
    chk("rf_flush_off", bus.flush_o, 0);
    chk("rf_stall_off", bus.fetch_stall_o, 0);
    rst = 1'b1;
    bus.instr_i = 16'h0298;
    bus.instr_valid_i = 1'b1;
    tick();
    chk("rf_run_accept", bus.ex_valid_o, 1);
    chk("rf_run_flush", bus.flush_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
